// File: rtl/reg_file_pkg.sv
// Shared constants and scoreboard rule for the multi-port register file.
// Imported by the top level and its read-port slices.
package reg_file_pkg;

   localparam int DW_DEF    = 32;
   localparam int DEPTH_DEF = 16;
   localparam int NRD_DEF   = 2;
   localparam int ZERO_IDX  = 0;

   // A reservation beats a same-cycle write: the reserving instruction is the newer producer.
   function automatic logic next_busy(input logic cur,
                                      input logic wr0_hit,
                                      input logic wr1_hit,
                                      input logic rsv_hit);
      if (rsv_hit)
         return 1'b1;
      if (wr0_hit || wr1_hit)
         return 1'b0;
      return cur;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: select mux, write-first bypass and output registers.
// Out-of-range selects read as zero and not busy.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_sel,
   input  logic [DW-1:0]    i_regs [DEPTH],
   input  logic [DEPTH-1:0] i_busy_nxt,
   input  logic             i_wr0_ok,
   input  logic [AW-1:0]    i_wr0_sel,
   input  logic [DW-1:0]    i_wr0_data,
   input  logic             i_wr1_ok,
   input  logic [AW-1:0]    i_wr1_sel,
   input  logic [DW-1:0]    i_wr1_data,
   output logic [DW-1:0]    o_rd_data,
   output logic             o_rd_busy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic          w_in_range;
   logic [DW-1:0] w_data;
   logic          w_busy;
   logic [DW-1:0] r_data;
   logic          r_busy;

   assign w_in_range = ({1'b0, i_rd_sel} < DEPTH_W);

   always_comb begin
      // NOTE: defaults assigned first so every path drives the outputs; no latch is inferred.
      w_data = '0;
      w_busy = 1'b0;
      if (w_in_range) begin
         w_busy = i_busy_nxt[i_rd_sel];
         if (i_wr1_ok && (i_wr1_sel == i_rd_sel))
            w_data = i_wr1_data;
         else if (i_wr0_ok && (i_wr0_sel == i_rd_sel))
            w_data = i_wr0_data;
         else
            w_data = i_regs[i_rd_sel];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_busy <= 1'b0;
      end else if (en && i_rd_en) begin
         r_data <= w_data;
         r_busy <= w_busy;
      end
   end

   assign o_rd_data = r_data;
   assign o_rd_busy = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with two write ports, NRD registered read ports
// and a per-register pending-write scoreboard for RAW hazard detection.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter  int DW       = DW_DEF,
   parameter  int DEPTH    = DEPTH_DEF,
   parameter  int NRD      = NRD_DEF,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr0_en,
   input  logic [AW-1:0]     wr0_sel,
   input  logic [DW-1:0]     wr0_data,
   input  logic              wr1_en,
   input  logic [AW-1:0]     wr1_sel,
   input  logic [DW-1:0]     wr1_data,
   input  logic              rd_en,
   input  logic [NRD*AW-1:0] rd_sel,
   output logic [NRD*DW-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_sel,
   output logic [DEPTH-1:0]  busy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [DW-1:0]    r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic             w_wr0_ok, w_wr1_ok, w_rsv_ok;
   logic [DEPTH-1:0] w_wr0_dec, w_wr1_dec, w_rsv_dec;
   logic [DEPTH-1:0] w_busy_nxt;

   // Writable/reservable: inside the array and not the hardwired zero register.
   function automatic logic sel_ok(input logic [AW-1:0] sel);
      return ({1'b0, sel} < DEPTH_W) && !((ZERO_REG != 0) && (sel == AW'(ZERO_IDX)));
   endfunction

   assign w_wr0_ok  = wr0_en && sel_ok(wr0_sel);
   assign w_wr1_ok  = wr1_en && sel_ok(wr1_sel);
   assign w_rsv_ok  = rsv_en && sel_ok(rsv_sel);
   assign w_wr0_dec = w_wr0_ok ? (DEPTH'(1) << wr0_sel) : '0;
   assign w_wr1_dec = w_wr1_ok ? (DEPTH'(1) << wr1_sel) : '0;
   assign w_rsv_dec = w_rsv_ok ? (DEPTH'(1) << rsv_sel) : '0;

   always_comb begin
      w_busy_nxt = r_busy;
      for (int r = 0; r < DEPTH; r++)
         w_busy_nxt[r] = next_busy(r_busy[r], w_wr0_dec[r], w_wr1_dec[r], w_rsv_dec[r]);
   end

   // NOTE: the array is reset because reads right after reset must return zero; it is flops, not RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++)
            r_regs[r] <= '0;
         r_busy <= '0;
      end else if (en) begin
         for (int r = 0; r < DEPTH; r++) begin
            if (w_wr1_dec[r])
               r_regs[r] <= wr1_data;
            else if (w_wr0_dec[r])
               r_regs[r] <= wr0_data;
         end
         r_busy <= w_busy_nxt;
      end
   end

   assign busy = r_busy;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      reg_file_rd_port #(
         .DW    (DW),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_rd_port (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .i_rd_en    (rd_en),
         .i_rd_sel   (rd_sel[k*AW +: AW]),
         .i_regs     (r_regs),
         .i_busy_nxt (w_busy_nxt),
         .i_wr0_ok   (w_wr0_ok),
         .i_wr0_sel  (wr0_sel),
         .i_wr0_data (wr0_data),
         .i_wr1_ok   (w_wr1_ok),
         .i_wr1_sel  (wr1_sel),
         .i_wr1_data (wr1_data),
         .o_rd_data  (rd_data[k*DW +: DW]),
         .o_rd_busy  (rd_busy[k])
      );
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus applies each cycle to an array model
// and queues expected read results; an independent monitor pops and compares.
module tb_reg_file_sb;

   localparam int DW       = 32;
   localparam int DEPTH    = 12;
   localparam int NRD      = 2;
   localparam int ZERO_REG = 1;
   localparam int AW       = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              wr0_en, wr1_en, rd_en, rsv_en;
   logic [AW-1:0]     wr0_sel, wr1_sel, rsv_sel;
   logic [DW-1:0]     wr0_data, wr1_data;
   logic [NRD*AW-1:0] rd_sel;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [DEPTH-1:0]  busy;

   always #5 clk = ~clk;

   reg_file_sb #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .wr0_en   (wr0_en),
      .wr0_sel  (wr0_sel),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_sel  (wr1_sel),
      .wr1_data (wr1_data),
      .rd_en    (rd_en),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .rsv_en   (rsv_en),
      .rsv_sel  (rsv_sel),
      .busy     (busy)
   );

   typedef struct {
      logic [NRD*DW-1:0] data;
      logic [NRD-1:0]    bsy;
   } exp_t;

   typedef struct {
      bit        en;
      bit        w0e;
      int        w0s;
      logic [31:0] w0d;
      bit        w1e;
      int        w1s;
      logic [31:0] w1d;
      bit        re;
      int        s0;
      int        s1;
      bit        rv;
      int        rs;
   } stim_t;

   exp_t        exp_q[$];
   exp_t        last_exp;
   int          checks   = 0;
   int          failures = 0;
   logic [DW-1:0]    m_regs [DEPTH];
   logic [DEPTH-1:0] m_busy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   function automatic bit writable(input int sel);
      return (sel < DEPTH) && !(ZERO_REG != 0 && sel == 0);
   endfunction

   function automatic logic [DW-1:0] m_read(input int sel);
      return (sel < DEPTH) ? m_regs[sel] : '0;
   endfunction

   function automatic logic m_rbusy(input int sel);
      return (sel < DEPTH) ? m_busy[sel] : 1'b0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{en: 1'b1, w0e: 1'b0, w0s: 0, w0d: '0, w1e: 1'b0, w1s: 0, w1d: '0,
            re: 1'b0, s0: 0, s1: 0, rv: 1'b0, rs: 0};
      return s;
   endfunction

   function automatic stim_t rd(input int a, input int b);
      stim_t s;
      s = idle();
      s.re = 1'b1;
      s.s0 = a;
      s.s1 = b;
      return s;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < DEPTH; r++)
         m_regs[r] = '0;
      m_busy = '0;
      last_exp = '{data: '0, bsy: '0};
   endtask

   // One clock of stimulus. The model applies the cycle's writes in order (port 1 last),
   // then its reservation; a same-cycle read observes that resulting state.
   task automatic cycle(input stim_t s);
      exp_t e;
      @(negedge clk);
      en       = s.en;
      wr0_en   = s.w0e;  wr0_sel = AW'(s.w0s);  wr0_data = s.w0d;
      wr1_en   = s.w1e;  wr1_sel = AW'(s.w1s);  wr1_data = s.w1d;
      rsv_en   = s.rv;   rsv_sel = AW'(s.rs);
      rd_en    = s.re;
      rd_sel   = {AW'(s.s1), AW'(s.s0)};
      if (s.en) begin
         if (s.w0e && writable(s.w0s)) begin m_regs[s.w0s] = s.w0d; m_busy[s.w0s] = 1'b0; end
         if (s.w1e && writable(s.w1s)) begin m_regs[s.w1s] = s.w1d; m_busy[s.w1s] = 1'b0; end
         if (s.rv && writable(s.rs)) m_busy[s.rs] = 1'b1;
         if (s.re) begin
            e.data = {m_read(s.s1), m_read(s.s0)};
            e.bsy  = {m_rbusy(s.s1), m_rbusy(s.s0)};
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      check("busy_vec", 64'(busy), 64'(m_busy));
   endtask

   // Monitor: a read accepted at this edge must appear 1 ns later; otherwise outputs hold.
   always @(posedge clk) begin : mon
      bit fire;
      fire = (en === 1'b1) && (rd_en === 1'b1) && (rst === 1'b0);
      #1;
      if (fire) begin
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_queue at %0t: read presented with no expected entry", $time);
         end else begin
            last_exp = exp_q.pop_front();
         end
      end
      check("rd_data", 64'(rd_data), 64'(last_exp.data));
      check("rd_busy", 64'(rd_busy), 64'(last_exp.bsy));
   end

   initial begin
      stim_t s;
      model_reset();
      rst = 1'b1;
      en = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rd_en = 1'b0; rsv_en = 1'b0;
      wr0_sel = '0; wr1_sel = '0; rsv_sel = '0; rd_sel = '0;
      wr0_data = '0; wr1_data = '0;
      #100;
      check("reset_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      cycle(rd(0, 1));

      s = idle(); s.w0e = 1; s.w0s = 2; s.w0d = 32'hABCDEFAB; cycle(s);
      s = idle(); s.w1e = 1; s.w1s = 3; s.w1d = 32'h01234567; cycle(s);
      cycle(rd(2, 3));

      s = rd(5, 5); s.w0e = 1; s.w0s = 5; s.w0d = 32'h11111111;
      s.w1e = 1; s.w1s = 5; s.w1d = 32'h22222222; cycle(s);
      cycle(rd(5, 2));

      s = idle(); s.rv = 1; s.rs = 7; cycle(s);
      cycle(rd(7, 6));
      s = rd(7, 7); s.w0e = 1; s.w0s = 7; s.w0d = 32'h0BADF00D; s.rv = 1; s.rs = 7; cycle(s);
      s = rd(7, 0); s.w1e = 1; s.w1s = 7; s.w1d = 32'hCAFEBABE; cycle(s);

      s = rd(0, 0); s.w0e = 1; s.w0s = 0; s.w0d = 32'hFFFFFFFF; s.rv = 1; s.rs = 0; cycle(s);
      s = rd(14, 13); s.w0e = 1; s.w0s = 14; s.w0d = 32'h5A5A5A5A;
      s.w1e = 1; s.w1s = 15; s.w1d = 32'hA5A5A5A5; s.rv = 1; s.rs = 14; cycle(s);
      for (int r = 0; r < 16; r += 2)
         cycle(rd(r, r + 1));

      for (int i = 0; i < 20; i++) begin
         s.en  = 1'b0;
         s.w0e = 1; s.w0s = int'($urandom_range(0, 15)); s.w0d = $urandom();
         s.w1e = 1; s.w1s = int'($urandom_range(0, 15)); s.w1d = $urandom();
         s.re  = 1; s.s0 = int'($urandom_range(0, 15)); s.s1 = int'($urandom_range(0, 15));
         s.rv  = 1; s.rs = int'($urandom_range(0, 15));
         cycle(s);
      end
      s = idle(); s.w0e = 1; s.w0s = 9; s.w0d = 32'h99999999; cycle(s);

      for (int i = 0; i < 400; i++) begin
         s.en  = ($urandom_range(0, 9) != 0);
         s.w0e = $urandom_range(0, 1) != 0; s.w0s = int'($urandom_range(0, 15)); s.w0d = $urandom();
         s.w1e = $urandom_range(0, 2) == 0; s.w1s = int'($urandom_range(0, 15)); s.w1d = $urandom();
         s.re  = $urandom_range(0, 2) != 0;
         s.s0  = int'($urandom_range(0, 15)); s.s1 = int'($urandom_range(0, 15));
         s.rv  = $urandom_range(0, 2) == 0; s.rs = int'($urandom_range(0, 15));
         cycle(s);
      end

      s = idle(); s.rv = 1; s.rs = 4; s.w0e = 1; s.w0s = 3; s.w0d = 32'h33333333; cycle(s);
      cycle(rd(3, 4));
      @(negedge clk);
      en = 1'b1; rd_en = 1'b1; rd_sel = {AW'(3), AW'(3)};
      wr0_en = 1'b1; wr0_sel = AW'(3); wr0_data = 32'h77777777;
      rsv_en = 1'b1; rsv_sel = AW'(6);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rd_data", 64'(rd_data), 64'(0));
      check("async_rd_busy", 64'(rd_busy), 64'(0));
      check("async_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      rd_en = 1'b0; wr0_en = 1'b0; rsv_en = 1'b0;
      cycle(rd(3, 6));
      cycle(rd(2, 5));

      @(negedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rd_queue_drain: %0d expected reads never presented", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-port register file with a pending-write scoreboard, successor to the single-write/dual-read regFile. Serves as the operand store of the pipelined core: NRD registered read ports, two write ports (ALU and load return) with write-first bypass, optional hardwired zero register, and per-register busy bits so issue logic can detect RAW hazards.

Parameters:
DW, 32, data width in bits
DEPTH, 16, number of registers (need not be a power of 2)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, cannot be reserved
AW (localparam), $clog2(DEPTH), select width

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous, active-high
en  in  1  global enable; 0 = no state change, outputs hold
wr0_en  in  1  write port 0 enable (ALU)
wr0_sel  in  AW  write port 0 register select
wr0_data  in  DW  write port 0 data
wr1_en  in  1  write port 1 enable (load return)
wr1_sel  in  AW  write port 1 register select
wr1_data  in  DW  write port 1 data
rd_en  in  1  read strobe, all read ports
rd_sel  in  NRD*AW  packed read selects, port k at [k*AW +: AW]
rd_data  out  NRD*DW  packed registered read data
rd_busy  out  NRD  registered busy flag per read port
rsv_en  in  1  reserve request (mark destination pending)
rsv_sel  in  AW  register to reserve
busy  out  DEPTH  live scoreboard vector

Behaviour:
- Reset (rst=1, async): all registers 0, busy 0, rd_data 0, rd_busy 0. Reset mid-operation discards in-flight writes/reservations in that cycle.
- All updates on rising clk and only when en=1; en=0 freezes registers, busy, rd_data, rd_busy.
- Write: wrN_en=1 stores wrN_data into wrN_sel. Both ports same register in same cycle: port 1 wins.
- Read: rd_en=1 samples; rd_data/rd_busy valid the cycle after (latency 1). rd_en=0: rd_data and rd_busy hold.
- Bypass (write-first): if rd_sel[k] equals an enabled write select in the same cycle, rd_data[k] gets the written data (port 1 priority), not the old value.
- Scoreboard next-state per register r: clear if written this cycle; then set if rsv_en and rsv_sel=r. Reserve and write to the same register in the same cycle: busy=1 (new producer wins).
- rd_busy[k] = next-state busy of rd_sel[k] (after same-cycle write/reserve), registered with rd_data.
- busy output is the current register state (no combinational input path).
- ZERO_REG=1: writes and reserves to 0 ignored; reads of 0 return 0, rd_busy 0; busy[0] always 0.
- Select >= DEPTH (non-power-of-2): writes/reserves ignored; reads return 0 with rd_busy 0.
- No arithmetic; data passed bit-exact at DW.

Decomposition:
- Package reg_file_pkg: default DW/DEPTH/NRD constants, localparam for zero-register index, function next_busy(cur, wr hits, rsv hit).
- One sub-module natural: reg_file_rd_port, instantiated NRD times via generate; one read port's mux, bypass compare and output registers.
- Storage array and scoreboard stay in top level.

Test Plan:
- Reset: rst=1 for 100 ns, then read regs 0 and 1 -> rd_data=0, rd_busy=0, busy=0.
- Basic: en=1, write 0xABCDEFAB to r2 via wr0, then 0x01234567 to r3 via wr1; read rd_sel={r3,r2} -> one cycle later port0=0xABCDEFAB, port1=0x01234567.
- Collision/bypass: wr0 and wr1 both to r5 (0x11111111, 0x22222222) with rd_en reading r5 the same cycle -> rd_data=0x22222222 next cycle; r5 holds 0x22222222.
- Scoreboard: reserve r7 -> busy[7]=1; read r7 -> rd_busy=1; write r7 while reserving r7 -> busy[7] stays 1; write r7 alone -> busy[7]=0.
- Zero reg/range: ZERO_REG=1, write 0xFFFFFFFF to r0 and reserve r0 -> read r0 = 0, busy[0]=0; DEPTH=12, write r14 -> no register changes, read r14 = 0.
- Hold/async reset: en=0 with writes, reserves, rd_en pulses -> all state and outputs unchanged; assert rst mid-clock -> outputs 0 immediately, before next edge.
